// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader.
// Holds the loader FSM and receiver FSM state encodings plus the size of
// the little-endian length header that precedes every program image.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        LD_WAIT_LEN,
        LD_LOAD,
        LD_START,
        LD_RUN,
        LD_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   uart_rx    - serial line, idle high, asynchronous to clk
//   rx_byte    - last correctly framed byte (valid with byte_valid)
//   byte_valid - one-cycle strobe, stop bit sampled high
//   frame_err  - one-cycle strobe, stop bit sampled low (byte dropped)
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic          sync_1;
    logic          sync_2;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= uart_rx;
            sync_2 <= sync_1;
        end
    end

    // Receiver FSM: the half-bit wait in START moves every later sample to
    // the centre of its bit; a start bit that is gone by then is a glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!sync_2) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync_2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        shift <= {sync_2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync_2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image received over UART into memory, then runs the CPU.
// Frame: 4-byte little-endian length, then that many payload bytes.
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous, active-low reset
//   uart_rx        - serial input, idle high
//   programAddress - byte address of the current write
//   programByte    - data of the current write
//   programWrEn    - one-cycle write strobe
//   startProgram   - high once the image is loaded, then stays high
//   cpu_reset      - active-high CPU reset, released one cycle after start
//   load_error     - sticky error flag
//   bytes_loaded   - payload bytes written so far
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_LEN      = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [31:0] programAddress,
    output logic [7:0]  programByte,
    output logic        programWrEn,
    output logic        startProgram,
    output logic        cpu_reset,
    output logic        load_error,
    output logic [31:0] bytes_loaded
);

    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          frame_err;
    loader_state_t state;
    logic [31:0]   len;
    logic [1:0]    len_idx;
    logic [31:0]   next_len;
    logic [31:0]   next_count;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Header bytes arrive LSB first, so each one shifts in from the top.
    assign next_len   = {rx_byte, len[31:8]};
    assign next_count = bytes_loaded + 32'd1;

    // Loader FSM: START lasts one cycle so the CPU sees the memory in run
    // mode while still held in reset; RUN and ERROR are terminal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= LD_WAIT_LEN;
            len            <= '0;
            len_idx        <= '0;
            programAddress <= '0;
            programByte    <= '0;
            programWrEn    <= 1'b0;
            startProgram   <= 1'b0;
            cpu_reset      <= 1'b1;
            load_error     <= 1'b0;
            bytes_loaded   <= '0;
        end else begin
            programWrEn <= 1'b0;
            case (state)
                LD_WAIT_LEN: begin
                    if (frame_err) begin
                        state      <= LD_ERROR;
                        load_error <= 1'b1;
                    end else if (byte_valid) begin
                        len     <= next_len;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'(LEN_BYTES - 1)) begin
                            if (next_len == 32'd0) begin
                                state <= LD_START;
                            end else if (next_len > 32'(MAX_LEN)) begin
                                state      <= LD_ERROR;
                                load_error <= 1'b1;
                            end else begin
                                state <= LD_LOAD;
                            end
                        end
                    end
                end
                LD_LOAD: begin
                    if (frame_err) begin
                        state      <= LD_ERROR;
                        load_error <= 1'b1;
                    end else if (byte_valid) begin
                        programWrEn    <= 1'b1;
                        programByte    <= rx_byte;
                        programAddress <= bytes_loaded;
                        bytes_loaded   <= next_count;
                        if (next_count == len) begin
                            state <= LD_START;
                        end
                    end
                end
                LD_START: begin
                    if (frame_err) begin
                        state      <= LD_ERROR;
                        load_error <= 1'b1;
                    end else begin
                        startProgram <= 1'b1;
                        state        <= LD_RUN;
                    end
                end
                LD_RUN: begin
                    startProgram <= 1'b1;
                    cpu_reset    <= 1'b0;
                end
                LD_ERROR: begin
                    load_error   <= 1'b1;
                    cpu_reset    <= 1'b1;
                    startProgram <= 1'b0;
                end
                default: begin
                    state      <= LD_ERROR;
                    load_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader with CLKS_PER_BIT = 8.
// Sends directed UART frames and compares the memory write stream and the
// status outputs against hand-computed values.
module tb_uart_program_loader;

    localparam int CPB = 8;

    logic        clk;
    logic        reset;
    logic        uart_rx;
    logic [31:0] programAddress;
    logic [7:0]  programByte;
    logic        programWrEn;
    logic        startProgram;
    logic        cpu_reset;
    logic        load_error;
    logic [31:0] bytes_loaded;

    int checks;
    int errors;
    int start_rst_count;
    int base;
    int start_base;
    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_LEN     (1048576)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .programAddress(programAddress),
        .programByte   (programByte),
        .programWrEn   (programWrEn),
        .startProgram  (startProgram),
        .cpu_reset     (cpu_reset),
        .load_error    (load_error),
        .bytes_loaded  (bytes_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every write strobe and every cycle with start high while the
    // CPU is still held in reset.
    always @(negedge clk) begin
        if (programWrEn) begin
            wr_addr.push_back(programAddress);
            wr_data.push_back(programByte);
        end
        if (startProgram && cpu_reset) begin
            start_rst_count <= start_rst_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One 8N1 frame with a selectable stop level, followed by idle time.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic checkWrite(input string tag, input int idx,
                              input logic [31:0] addr, input logic [7:0] data);
        logic [31:0] obs_a;
        logic [7:0]  obs_d;
        obs_a = 32'hDEAD_BEEF;
        obs_d = 8'hEE;
        if (base + idx < wr_addr.size()) begin
            obs_a = wr_addr[base + idx];
            obs_d = wr_data[base + idx];
        end
        checkOutput({tag, "_addr"}, obs_a, addr);
        checkOutput({tag, "_data"}, {24'd0, obs_d}, {24'd0, data});
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        base       = wr_addr.size();
        start_base = start_rst_count;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        start_rst_count = 0;
        base            = 0;
        start_base      = 0;
        uart_rx         = 1'b1;
        reset           = 1'b0;

        // Reset values with the line idle
        repeat (4) @(negedge clk);
        checkOutput("rst_addr", programAddress, 32'd0);
        checkOutput("rst_byte", {24'd0, programByte}, 32'd0);
        checkOutput("rst_wren", {31'd0, programWrEn}, 32'd0);
        checkOutput("rst_start", {31'd0, startProgram}, 32'd0);
        checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("rst_err", {31'd0, load_error}, 32'd0);
        checkOutput("rst_count", bytes_loaded, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);

        // Three-byte image
        base       = wr_addr.size();
        start_base = start_rst_count;
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t1_cpu_reset_during_load", {31'd0, cpu_reset}, 32'd1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("t1_wr_count", wr_addr.size() - base, 32'd3);
        checkWrite("t1_w0", 0, 32'd0, 8'h11);
        checkWrite("t1_w1", 1, 32'd1, 8'h22);
        checkWrite("t1_w2", 2, 32'd2, 8'h33);
        checkOutput("t1_start", {31'd0, startProgram}, 32'd1);
        checkOutput("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        checkOutput("t1_start_rst_cycles", start_rst_count - start_base, 32'd1);
        checkOutput("t1_bytes_loaded", bytes_loaded, 32'd3);
        checkOutput("t1_addr_hold", programAddress, 32'd2);
        checkOutput("t1_err", {31'd0, load_error}, 32'd0);

        // Start-bit glitch then an empty image
        doReset();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("t2_wr_count", wr_addr.size() - base, 32'd0);
        checkOutput("t2_start", {31'd0, startProgram}, 32'd1);
        checkOutput("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        checkOutput("t2_err", {31'd0, load_error}, 32'd0);
        checkOutput("t2_start_rst_cycles", start_rst_count - start_base, 32'd1);

        // Framing error in the payload
        doReset();
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h5A, 1'b0);
        applyStimulus(8'h77, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("t3_err", {31'd0, load_error}, 32'd1);
        checkOutput("t3_wr_count", wr_addr.size() - base, 32'd0);
        checkOutput("t3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("t3_start", {31'd0, startProgram}, 32'd0);

        // Oversized length header
        doReset();
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("t4_err", {31'd0, load_error}, 32'd1);
        checkOutput("t4_wr_count", wr_addr.size() - base, 32'd0);
        checkOutput("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("t4_start", {31'd0, startProgram}, 32'd0);

        // Reset mid-load, then a full resend
        doReset();
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        checkOutput("t5_partial_count", bytes_loaded, 32'd2);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_count", bytes_loaded, 32'd0);
        checkOutput("t5_rst_addr", programAddress, 32'd0);
        checkOutput("t5_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        base       = wr_addr.size();
        start_base = start_rst_count;
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        repeat (10) @(negedge clk);
        checkWrite("t5_w0", 0, 32'd0, 8'hAA);
        checkWrite("t5_w1", 1, 32'd1, 8'hBB);
        checkOutput("t5_start", {31'd0, startProgram}, 32'd1);
        checkOutput("t5_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        applyStimulus(8'hCC, 1'b1);
        applyStimulus(8'hDD, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("t5_wr_count_after_run", wr_addr.size() - base, 32'd2);
        checkOutput("t5_bytes_loaded", bytes_loaded, 32'd2);
        checkOutput("t5_start_held", {31'd0, startProgram}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Upstream of the CPU/memory testbench. Receives a program image over an 8N1 UART line and drives the memory programming port (programAddress/programByte/programWrEn/startProgram).
- Holds the CPU in reset during loading, then releases it.
- Replaces the file/bench-driven programming path on hardware.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- MAX_LEN, 1048576, largest accepted image length in bytes (matches memory depth).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- programAddress  out  32  byte address for current write
- programByte  out  8  data byte for current write
- programWrEn  out  1  one-cycle write strobe
- startProgram  out  1  high once image fully loaded; stays high
- cpu_reset  out  1  active-high synchronous reset to cpu; high until run
- load_error  out  1  sticky error flag
- bytes_loaded  out  32  count of payload bytes written so far

Behaviour:
- Reset (reset=0, async) values:
  - programAddress=0, programByte=0, programWrEn=0, startProgram=0, cpu_reset=1, load_error=0, bytes_loaded=0.
  - RX and loader FSMs in IDLE/WAIT_LEN; length register 0.
- RX synchroniser: 2 flops on uart_rx; all RX logic uses the synchronised signal (2-cycle input latency).
- RX FSM (sub-module):
  - IDLE: wait for low.
  - START: count CLKS_PER_BIT/2 (integer divide), resample. Low -> DATA. High -> IDLE (glitch rejected, no output).
  - DATA: 8 samples, CLKS_PER_BIT apart, LSB first.
  - STOP: after CLKS_PER_BIT, sample. High -> byte_valid for 1 cycle with byte. Low -> frame_err for 1 cycle, byte dropped.
  - Both STOP outcomes return to IDLE. No break detection.
- Loader FSM:
  - WAIT_LEN: collect 4 bytes, little-endian, into len[31:0]. After the 4th byte:
    - len==0 -> START
    - len>MAX_LEN -> ERROR
    - otherwise -> LOAD.
  - LOAD: on each byte_valid, the next cycle drives programWrEn=1, programByte=byte, programAddress=bytes_loaded. bytes_loaded increments in that same cycle. Write latency from byte_valid = 1 cycle. When bytes_loaded reaches len -> START.
  - START: 1 cycle. startProgram<=1, cpu_reset stays 1, so the cpu sees at least one reset cycle with the memory already in run mode.
  - RUN: cpu_reset<=0, startProgram held 1. All further RX bytes ignored. Terminal until reset.
  - ERROR: load_error=1, cpu_reset=1, startProgram=0, no writes. Terminal until reset.
- frame_err in any state other than RUN -> ERROR. In RUN it is ignored.
- programWrEn is never asserted outside LOAD. Max one write per received byte, so back-to-back writes never occur (≥10·CLKS_PER_BIT apart).
- Reset mid-operation: immediate return to reset values. Partially written memory is not cleared. The host must resend the full frame including the length header.
- programAddress holds its last value between strobes. It is updated only with programWrEn.
- bytes_loaded width is 32 bits. No wrap is possible since len ≤ MAX_LEN.

Decomposition:
- Shared package holds:
  - loader state encoding (WAIT_LEN, LOAD, START, RUN, ERROR)
  - RX state encoding (IDLE, START, DATA, STOP)
  - LEN_BYTES=4 constant.
- One sub-module, uart_rx: synchroniser + RX FSM. Outputs byte[7:0], byte_valid, frame_err.
- Length assembly, address counter and loader FSM stay in uart_program_loader.

Test Plan:
- All tests use CLKS_PER_BIT=8.
- Reset asserted with line idle -> all outputs at reset values; cpu_reset=1 throughout.
- Frame 03 00 00 00 11 22 33 -> 3 programWrEn pulses: (0,0x11), (1,0x22), (2,0x33). Then startProgram=1 with cpu_reset=1 for exactly 1 cycle, then cpu_reset=0. bytes_loaded=3.
- uart_rx low for 2 clk then high, followed by valid frame 00 00 00 00 -> glitch produces no byte. startProgram=1 with zero writes.
- Byte 0x5A sent with stop bit low during the payload of a len=2 frame -> load_error=1. No further programWrEn. cpu_reset stays 1.
- Header 01 00 10 00 (len=0x100001 > MAX_LEN) -> load_error=1, no writes.
- reset pulsed low after 2 of 4 payload bytes, then full frame 02 00 00 00 AA BB resent -> writes (0,0xAA), (1,0xBB), then startProgram=1. Bytes sent after RUN cause no writes.
